// File: rtl/counter_initiator.sv
// Four-phase initiator that turns buffered increment requests into addReq/addFin
// handshakes toward an asynchronous counter, mirroring the completed count locally.
module counter_initiator #(
   parameter int N           = 10,
   parameter int PEND_DEPTH  = 8,
   parameter int TIMEOUT     = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            incValid,
   output logic                            incReady,
   output logic                            addReq,
   input  logic                            addFin,
   output logic [$clog2(PEND_DEPTH+1)-1:0] pending,
   output logic [$clog2(N)-1:0]            count,
   output logic                            wrap,
   output logic                            busy,
   output logic                            err,
   output logic [1:0]                      dbg_state
);

   localparam int PW = $clog2(PEND_DEPTH + 1);
   localparam int CW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, REL = 2'd2, ERR = 2'd3} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] prime_q;
   logic                   fin_s;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   add_req_d, wrap_d, err_d;
   logic [PW-1:0]          pending_d;
   logic [CW-1:0]          count_d;
   logic                   accept, issue;

   // prime_q fills in lockstep with sync_q so no request is issued on the
   // reset-zeroed synchronizer contents before addFin has propagated through.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         prime_q <= '0;
      end else begin
         sync_q[0]  <= addFin;
         prime_q[0] <= 1'b1;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i]  <= sync_q[i-1];
            prime_q[i] <= prime_q[i-1];
         end
      end
   end

   assign fin_s     = sync_q[SYNC_STAGES-1];
   assign incReady  = !rst && !err && (state_q != ERR) && (pending < PW'(PEND_DEPTH));
   assign accept    = incValid && incReady;
   assign issue     = (state_q == IDLE) && (pending != '0) && !fin_s && prime_q[SYNC_STAGES-1];
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      add_req_d = addReq;
      timer_d   = timer_q;
      count_d   = count;
      wrap_d    = 1'b0;
      err_d     = err;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d   = REQ;
               add_req_d = 1'b1;
               timer_d   = '0;
            end
         end
         REQ: begin
            if (fin_s) begin
               state_d   = REL;
               add_req_d = 1'b0;
               timer_d   = '0;
               wrap_d    = (count == CW'(N - 1));
               count_d   = (count == CW'(N - 1)) ? '0 : count + 1'b1;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d   = ERR;
               add_req_d = 1'b0;
               err_d     = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         REL: begin
            if (!fin_s) begin
               state_d = IDLE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d   = ERR;
               add_req_d = 1'b0;
               err_d     = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ERR: begin
            add_req_d = 1'b0;
         end
         default: begin
            state_d   = IDLE;
            add_req_d = 1'b0;
         end
      endcase
   end

   // Accept and issue in the same cycle cancel out.
   always_comb begin
      pending_d = pending;
      case ({accept, issue})
         2'b10:   pending_d = pending + 1'b1;
         2'b01:   pending_d = pending - 1'b1;
         default: pending_d = pending;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addReq  <= 1'b0;
         pending <= '0;
         count   <= '0;
         wrap    <= 1'b0;
         err     <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         addReq  <= add_req_d;
         pending <= pending_d;
         count   <= count_d;
         wrap    <= wrap_d;
         err     <= err_d;
         timer_q <= timer_d;
      end
   end

endmodule

// File: doc/counter_initiator.md
COUNTER_INITIATOR -- requirements
Module: counter_initiator

Interface
REQ-001 Parameter N, default 10, shall set the counter modulus: counts 0..N-1, then wrap.
REQ-002 Parameter PEND_DEPTH, default 8, shall set the maximum number of buffered increment requests.
REQ-003 Parameter TIMEOUT, default 255, shall set the maximum number of cycles one handshake phase may wait before error.
REQ-004 Parameter SYNC_STAGES, default 2, shall set the synchronizer depth on addFin.
REQ-005 Port clk, input, 1, shall be the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, shall be the reset: synchronous, active-high.
REQ-007 Port incValid, input, 1, shall be the increment request from upstream.
REQ-008 Port incReady, output, 1, shall mean an increment is accepted this cycle if incValid=1.
REQ-009 Port addReq, output, 1, shall be the four-phase request toward the asynchronous counter; it is driven directly from a flop.
REQ-010 Port addFin, input, 1, shall be the asynchronous four-phase acknowledge from the counter.
REQ-011 Port pending, output, $clog2(PEND_DEPTH+1), shall be the number of accepted but not yet issued increments.
REQ-012 Port count, output, $clog2(N), shall be the local mirror of completed increments mod N.
REQ-013 Port wrap, output, 1, shall be a one-cycle pulse when count wraps N-1 -> 0.
REQ-014 Port busy, output, 1, shall be high whenever the FSM is not IDLE.
REQ-015 Port err, output, 1, shall be a sticky handshake-timeout flag.

Function
REQ-016 addFin shall pass through a SYNC_STAGES flop synchronizer; all FSM decisions shall use only the synchronized value finS.
REQ-017 incReady shall equal (pending < PEND_DEPTH) && !err; acceptance = incValid && incReady.
REQ-018 The FSM states shall be IDLE, REQ, REL, ERR.
REQ-019 In IDLE: if pending > 0 and finS = 0, go to REQ, set addReq = 1, decrement pending.
REQ-020 In REQ: addReq = 1; on finS = 1, go to REL, set addReq = 0, and increment count.
REQ-021 In REL: addReq = 0; on finS = 0, go to IDLE. A new request is issued at the earliest one cycle later.
REQ-022 Count wrap: if count = N-1 when incremented, count shall go to 0 and wrap shall pulse high for exactly that cycle.
REQ-023 Acceptance and issue in the same cycle shall leave pending unchanged; pending shall never exceed PEND_DEPTH or underflow.
REQ-024 A phase timer shall clear on each REQ or REL entry and increment each cycle in those states.
REQ-025 If the phase timer reaches TIMEOUT, the FSM shall go to ERR, drive addReq = 0, and set err = 1.
REQ-026 ERR shall be left only by rst; in ERR no acceptance, no issue, and pending and count hold.
REQ-027 addReq shall never rise while finS = 1.
REQ-028 Throughput shall be at most one completed increment per 2*(SYNC_STAGES+1) cycles; no increment shall be lost or duplicated.

Reset
REQ-029 While rst = 1 at a clock edge: state = IDLE; addReq, pending, count, wrap, err and the phase timer = 0; synchronizer flops = 0; incReady = 0.
REQ-030 Reset asserted mid-handshake shall drop addReq at that edge; in-flight and pending increments shall be discarded.
REQ-031 The first increment after reset shall wait for finS = 0 (REQ-019).

Verification
REQ-032 Single increment: one incValid pulse, model returns addFin 3 cycles after addReq, releases 3 cycles after drop -> addReq high once; count 0->1; pending 1->0; busy low at end.
REQ-033 Wrap: 10 increments with N=10 -> count 9->0; wrap high exactly one cycle; 10 addReq rising edges.
REQ-034 Backpressure: incValid held high with the responder stalled -> pending saturates at 8; incReady = 0; no acceptance lost or duplicated after release.
REQ-035 Simultaneous: accept and issue in the same cycle with pending = 3 -> pending stays 3.
REQ-036 Timeout: addFin stuck low -> after 255 cycles in REQ, err = 1, addReq = 0, incReady = 0; err stays 1 until rst.
REQ-037 Reset mid-REQ: rst for 1 cycle -> addReq = 0, count = 0, pending = 0 at that edge; no new request until addFin returns low.
